// File: rtl/frame_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : frame_sync_ctrl                                                  |
// | Brief   : Serial frame-alignment controller (hunt / verify / locked).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_sync_ctrl #(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] PATTERN    = 6'b110101,
    parameter int               FRAME_LEN  = 16,
    parameter int               LOCK_CNT   = 3,
    parameter int               UNLOCK_CNT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         input_en,
    input  logic                         sync_en,
    output logic                         locked,
    output logic                         frame_start,
    output logic                         miss_err,
    output logic                         lock_lost,
    output logic [1:0]                   state,
    output logic [$clog2(FRAME_LEN)-1:0] bit_pos
);

    localparam int BPW = $clog2(FRAME_LEN);
    localparam int HCW = $clog2(LOCK_CNT + 1);
    localparam int MCW = $clog2(UNLOCK_CNT + 1);

    localparam logic [BPW-1:0] C_LAST_POS = BPW'(FRAME_LEN - 1);
    localparam logic [HCW-1:0] C_LOCK_CNT = HCW'(LOCK_CNT);
    localparam logic [MCW-1:0] C_UNLK_CNT = MCW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-2:0] r_sr;
    logic [BPW-1:0]   r_bit_pos;
    logic [HCW-1:0]   r_hit_cnt;
    logic [MCW-1:0]   r_miss_cnt;
    logic             r_locked;
    logic             r_frame_start;
    logic             r_miss_err;
    logic             r_lock_lost;

    logic [WIDTH-1:0] w_window;
    logic             w_hit;
    logic             w_checkpoint;
    logic [BPW-1:0]   w_bit_pos_inc;
    logic [HCW-1:0]   w_hit_inc;
    logic [MCW-1:0]   w_miss_inc;

    // The oldest bit of the WIDTH-bit window is never needed again after the
    // compare, so only WIDTH-1 bits of history are stored.
    assign w_window      = {r_sr, data_in};
    assign w_hit         = (w_window == PATTERN);
    assign w_checkpoint  = (r_bit_pos == C_LAST_POS);
    assign w_bit_pos_inc = w_checkpoint ? '0 : r_bit_pos + BPW'(1);
    assign w_hit_inc     = r_hit_cnt + HCW'(1);
    assign w_miss_inc    = r_miss_cnt + MCW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_HUNT;
            r_sr          <= '0;
            r_bit_pos     <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_miss_err    <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_miss_err    <= 1'b0;
            r_lock_lost   <= 1'b0;

            if (input_en) begin
                r_sr <= w_window[WIDTH-2:0];
            end

            if (!sync_en) begin
                // Disable is a silent abort: no lock_lost, counters and position cleared.
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
                r_bit_pos  <= '0;
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end else if (input_en) begin
                r_bit_pos <= w_bit_pos_inc;

                case (r_state)
                    ST_HUNT: begin
                        if (w_hit) begin
                            r_bit_pos <= '0;
                            if (LOCK_CNT == 1) begin
                                r_state       <= ST_LOCKED;
                                r_locked      <= 1'b1;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state   <= ST_VERIFY;
                                r_hit_cnt <= HCW'(1);
                            end
                        end
                    end

                    ST_VERIFY: begin
                        if (w_checkpoint) begin
                            if (w_hit) begin
                                if (w_hit_inc == C_LOCK_CNT) begin
                                    r_state       <= ST_LOCKED;
                                    r_locked      <= 1'b1;
                                    r_frame_start <= 1'b1;
                                    r_hit_cnt     <= '0;
                                end else begin
                                    r_hit_cnt <= w_hit_inc;
                                end
                            end else begin
                                r_state   <= ST_HUNT;
                                r_hit_cnt <= '0;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        if (w_checkpoint) begin
                            if (w_hit) begin
                                r_miss_cnt    <= '0;
                                r_frame_start <= 1'b1;
                            end else if (w_miss_inc == C_UNLK_CNT) begin
                                r_state     <= ST_HUNT;
                                r_locked    <= 1'b0;
                                r_lock_lost <= 1'b1;
                                r_miss_cnt  <= '0;
                            end else begin
                                // Flywheel: keep the frame timing alive through the miss.
                                r_miss_cnt    <= w_miss_inc;
                                r_miss_err    <= 1'b1;
                                r_frame_start <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state    <= ST_HUNT;
                        r_locked   <= 1'b0;
                        r_hit_cnt  <= '0;
                        r_miss_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign miss_err    = r_miss_err;
    assign lock_lost   = r_lock_lost;
    assign state       = r_state;
    assign bit_pos     = r_bit_pos;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_frame_sync_ctrl                                               |
// | Brief   : Directed + randomized bench for frame_sync_ctrl with a beat model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_frame_sync_ctrl;

    localparam int         WIDTH      = 6;
    localparam logic [5:0] PATTERN    = 6'b110101;
    localparam int         FRAME_LEN  = 16;
    localparam int         LOCK_CNT   = 3;
    localparam int         UNLOCK_CNT = 2;
    localparam int         BPW        = $clog2(FRAME_LEN);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           data_in = 1'b0;
    logic           input_en = 1'b0;
    logic           sync_en = 1'b0;
    logic           locked;
    logic           frame_start;
    logic           miss_err;
    logic           lock_lost;
    logic [1:0]     state;
    logic [BPW-1:0] bit_pos;

    always #5 clk = ~clk;

    frame_sync_ctrl #(
        .WIDTH      (WIDTH),
        .PATTERN    (PATTERN),
        .FRAME_LEN  (FRAME_LEN),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .input_en    (input_en),
        .sync_en     (sync_en),
        .locked      (locked),
        .frame_start (frame_start),
        .miss_err    (miss_err),
        .lock_lost   (lock_lost),
        .state       (state),
        .bit_pos     (bit_pos)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: alignment is tracked by absolute beat numbers, a frame
    // boundary being any whole multiple of FRAME_LEN beats after the anchor.
    bit         m_hist[$];
    int         m_n, m_anchor, m_mode, m_hits, m_misses;
    bit         m_fs, m_me, m_ll;
    logic [5:0] pat_v = PATTERN;

    int   beats, verify_beat, lock_beat, n_ll, n_me;
    logic was_locked;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
        m_n = 0; m_anchor = 0; m_mode = 0; m_hits = 0; m_misses = 0;
        m_fs = 1'b0; m_me = 1'b0; m_ll = 1'b0;
    endfunction

    function automatic bit model_hit();
        bit h = 1'b1;
        for (int i = 0; i < WIDTH; i++)
            if (m_hist[m_hist.size() - 1 - i] != pat_v[i]) h = 1'b0;
        return h;
    endfunction

    function automatic void model_update(input bit d, input bit en, input bit se);
        bit hit, ckpt;
        m_fs = 1'b0; m_me = 1'b0; m_ll = 1'b0;
        if (en) begin
            m_hist.push_back(d);
            void'(m_hist.pop_front());
            m_n++;
        end
        if (!se) begin
            m_mode = 0; m_hits = 0; m_misses = 0; m_anchor = m_n;
            return;
        end
        if (!en) return;
        hit  = model_hit();
        ckpt = (m_mode != 0) && ((m_n - m_anchor) % FRAME_LEN == 0);
        if (m_mode == 0) begin
            if (hit) begin
                m_anchor = m_n;
                if (LOCK_CNT == 1) begin m_mode = 2; m_fs = 1'b1; end
                else begin m_mode = 1; m_hits = 1; end
            end
        end else if (m_mode == 1 && ckpt) begin
            if (hit) begin
                m_hits++;
                if (m_hits >= LOCK_CNT) begin m_mode = 2; m_hits = 0; m_fs = 1'b1; end
            end else begin
                m_mode = 0; m_hits = 0;
            end
        end else if (m_mode == 2 && ckpt) begin
            if (hit) begin
                m_misses = 0; m_fs = 1'b1;
            end else begin
                m_misses++;
                if (m_misses >= UNLOCK_CNT) begin m_mode = 0; m_misses = 0; m_ll = 1'b1; end
                else begin m_me = 1'b1; m_fs = 1'b1; end
            end
        end
    endfunction

    function automatic logic [9:0] dut_vec();
        return {locked, frame_start, miss_err, lock_lost, state, bit_pos};
    endfunction

    function automatic logic [9:0] model_vec();
        return {(m_mode == 2), m_fs, m_me, m_ll, 2'(m_mode),
                BPW'((m_n - m_anchor) % FRAME_LEN)};
    endfunction

    task automatic expect_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic en, input logic se);
        data_in  = d;
        input_en = en;
        sync_en  = se;
        @(posedge clk);
        model_update(d, en, se);
        if (en) beats++;
        #1;
        expect_v("cycle", 32'(dut_vec()), 32'(model_vec()));
        if (frame_start) expect_v("fs_bitpos", 32'(bit_pos), 32'd0);
        if (state == 2'd1 && verify_beat < 0) verify_beat = beats;
        if (locked && !was_locked && lock_beat < 0) lock_beat = beats;
        was_locked = locked;
        if (lock_lost) n_ll++;
        if (miss_err) n_me++;
    endtask

    task automatic send_frame(input logic [15:0] f, input int duty);
        for (int i = 15; i >= 0; i--) begin
            int idles = 0;
            while (idles < 8 && $urandom_range(0, 99) >= duty) begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                idles++;
            end
            step(f[i], 1'b1, 1'b1);
        end
    endtask

    // Asynchronous reset taken between clock edges, then released with input_en=0.
    task automatic restart();
        rst = 1'b0;
        input_en = 1'b0;
        #1;
        expect_v("async_rst", 32'(dut_vec()), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        beats = 0; verify_beat = -1; lock_beat = -1; n_ll = 0; n_me = 0; was_locked = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        expect_v("reset", 32'(dut_vec()), 32'd0);
    endtask

    localparam logic [15:0] CLEAN = {6'b110101, 10'b0};
    localparam logic [15:0] BAD   = 16'h0000;

    logic [15:0] fr;

    initial begin
        model_reset();

        // Acquisition with continuous beats.
        restart();
        repeat (5) send_frame(CLEAN, 100);
        expect_v("acq_verify_beat", 32'(verify_beat), 32'd6);
        expect_v("acq_lock_beat", 32'(lock_beat), 32'd38);

        // False sync in the payload during VERIFY, then a corrupted sync word.
        restart();
        send_frame({6'b110101, 10'b0110101000}, 100);
        expect_v("false_sync_verify", 32'(state), 32'd1);
        send_frame(BAD, 100);
        expect_v("false_sync_hunt", 32'(state), 32'd0);
        expect_v("false_sync_nolock", 32'(lock_beat), 32'hFFFF_FFFF);

        // Flywheel, recovery, then unlock on two consecutive misses.
        restart();
        repeat (3) send_frame(CLEAN, 100);
        send_frame(BAD, 100);
        expect_v("fly_miss", 32'(n_me), 32'd1);
        expect_v("fly_locked", 32'(locked), 32'd1);
        send_frame(CLEAN, 100);
        send_frame(BAD, 100);
        expect_v("fly_locked2", 32'(locked), 32'd1);
        send_frame(BAD, 100);
        expect_v("unlock_ll", 32'(n_ll), 32'd1);
        expect_v("unlock_me", 32'(n_me), 32'd2);
        expect_v("unlock_state", 32'(state), 32'd0);

        // Gapped input at 50% duty locks after the same number of beats.
        restart();
        repeat (5) send_frame(CLEAN, 50);
        expect_v("gap_lock_beat", 32'(lock_beat), 32'd38);

        // Abort: async reset mid-LOCKED, then a one-cycle sync_en drop.
        restart();
        repeat (4) send_frame(CLEAN, 100);
        fr = CLEAN;
        for (int i = 15; i > 7; i--) step(fr[i], 1'b1, 1'b1);
        expect_v("abort_locked", 32'(locked), 32'd1);
        restart();
        repeat (3) send_frame(CLEAN, 100);
        expect_v("relock", 32'(locked), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        expect_v("drop_state", 32'(state), 32'd0);
        expect_v("drop_locked", 32'(locked), 32'd0);
        expect_v("drop_ll", 32'(n_ll), 32'd0);
        repeat (2) send_frame(CLEAN, 100);
        expect_v("drop_not_yet", 32'(locked), 32'd0);
        send_frame(CLEAN, 100);
        expect_v("drop_relock", 32'(locked), 32'd1);

        // Randomized traffic: corrupted syncs, random payloads, slips, gaps, disables.
        restart();
        for (int k = 0; k < 250; k++) begin
            int duty;
            duty = ($urandom_range(0, 2) == 0) ? 50 : 100;
            if ($urandom_range(0, 99) < 3)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 99) < 4)
                step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            fr[15:10] = ($urandom_range(0, 99) < 15) ? 6'($urandom_range(0, 63)) : PATTERN;
            fr[9:0]   = 10'($urandom_range(0, 1023));
            send_frame(fr, duty);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
Frame-alignment controller for a serial bit stream. It holds its own WIDTH-bit shift register and pattern comparator, hunts for the sync PATTERN, and confirms alignment over LOCK_CNT consecutive frames before declaring lock. It then flywheels through up to UNLOCK_CNT-1 consecutive missed sync words and drops lock on the UNLOCK_CNT-th miss. It sits between the serial receive front end and the downstream deframer, and supplies lock status, frame-start strobes and the bit position within the frame.

Parameters:
PATTERN, 6'b110101, sync word; the newest bit is compared against bit 0.
WIDTH, 6, sync word length in bits; WIDTH >= 2.
FRAME_LEN, 16, frame length in bits, including the sync word; FRAME_LEN >= WIDTH.
LOCK_CNT, 3, consecutive aligned matches needed to lock, counting the hunt match; >= 1.
UNLOCK_CNT, 2, consecutive checkpoint misses in LOCKED that drop lock; >= 1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
data_in  input  1  serial data bit, valid when input_en=1
input_en  input  1  bit-valid strobe; one beat per cycle when high
sync_en  input  1  enable; low forces HUNT
locked  output  1  high while state is LOCKED
frame_start  output  1  one-cycle pulse marking an aligned sync-word end while locked
miss_err  output  1  one-cycle pulse on a checkpoint miss that does not drop lock
lock_lost  output  1  one-cycle pulse when LOCKED goes to HUNT because of misses
state  output  2  HUNT=0, VERIFY=1, LOCKED=2; 3 is never driven
bit_pos  output  $clog2(FRAME_LEN)  bit position within the frame; 0 = beat holding the last sync bit

Behaviour:
- Reset (rst=0, async): shift register, bit_pos, hit_cnt and miss_cnt clear to 0; state=HUNT; every output is 0.
- Beat: a cycle with input_en=1. When input_en=0, nothing changes and all pulse outputs are 0.
- Shift: on each beat, sr <= {sr[WIDTH-2:0], data_in}. This runs regardless of sync_en or state.
- Match: hit = ({sr[WIDTH-2:0], data_in} == PATTERN), evaluated combinationally on the beat itself, so there is zero-beat detection latency.
- Checkpoint: a beat with bit_pos==FRAME_LEN-1 in VERIFY or LOCKED.
- bit_pos increments on each beat and wraps from FRAME_LEN-1 to 0. In HUNT, a hit loads bit_pos<=0.
- All outputs are registered and appear the cycle after the deciding beat.
- HUNT, beat with hit:
  - LOCK_CNT==1: go to LOCKED and pulse frame_start.
  - otherwise: go to VERIFY with hit_cnt<=1.
  - Hits on any other beat leave HUNT unchanged.
- VERIFY:
  - Checkpoint with hit: hit_cnt+1. When hit_cnt reaches LOCK_CNT, go to LOCKED and pulse frame_start.
  - Checkpoint without hit: go to HUNT. This beat itself does not re-arm the hunt.
  - Non-checkpoint hits (false sync in the payload) are ignored.
- LOCKED:
  - Checkpoint with hit: miss_cnt<=0 and pulse frame_start.
  - Checkpoint without hit, miss_cnt+1 < UNLOCK_CNT: miss_cnt+1, pulse miss_err and pulse frame_start (flywheel).
  - Checkpoint without hit, miss_cnt+1 == UNLOCK_CNT: go to HUNT, pulse lock_lost, clear miss_cnt; no frame_start, no miss_err.
  - Non-checkpoint hits are ignored.
- Entering HUNT from any state clears hit_cnt and miss_cnt. bit_pos keeps counting but is meaningless until the next hit.
- sync_en=0: the next clock forces state=HUNT, clears hit_cnt, miss_cnt and bit_pos, and holds all pulse outputs at 0. lock_lost is NOT pulsed.
- sync_en rising: the hunt starts on the first beat with sync_en=1, and that beat may itself hit.
- Overlapping PATTERN occurrences need no special handling; alignment is purely positional.
- locked equals (state==LOCKED) after registering.
- At most one of frame_start, miss_err and lock_lost is set per cycle, except that miss_err and frame_start are set together on a flywheel miss.

Test Plan:
All scenarios use the default parameters unless stated.
- Reset: hold rst=0 for 3 cycles, then release with input_en=0 -> locked=0, frame_start=0, miss_err=0, lock_lost=0, state=0, bit_pos=0.
- Acquisition: continuous beats of frames [110101 + 10 zeros] -> state=1 after beat 6; locked=1 and frame_start=1 one cycle after beat 38; frame_start then pulses every 16 beats and bit_pos=0 at each pulse.
- False sync: in VERIFY, payload bits contain 110101 ending at bit_pos=7 -> no state change. Corrupt the next sync word to 000000 -> state=0 one cycle after that checkpoint; locked stays 0.
- Flywheel/unlock: while locked, corrupt one sync word -> miss_err=1 and frame_start=1 in the same cycle, locked stays 1. The next frame is clean -> miss_cnt clears. Then corrupt two consecutive sync words -> lock_lost=1 for 1 cycle, locked=0, state=0 on the second.
- Gapped input: repeat the acquisition with input_en at 50% random duty -> lock after the same 38 beats; no output changes on input_en=0 cycles.
- Abort: assert rst=0 asynchronously mid-LOCKED -> outputs go to 0 without a clock edge. Separately, drop sync_en for 1 cycle while locked -> state=0, locked=0, lock_lost stays 0; re-lock after 3 further aligned frames.
